micro_sequencer: RTL
====================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port micro_ad, input, 8 bits: branch target field of the current microword, {MICRO_AD_HIGH, MICRO_AD_LOW}.
REQ-004 SHALL have port count, input, 1 bit: when no load occurs, 1 increments microaddress and 0 holds it.
REQ-005 SHALL have port bop, input, 4 bits: branch operation field of the current microword.
REQ-006 SHALL have port opcode, input, 4 bits: opcode from the instruction register.
REQ-007 SHALL have port go_bar, input, 1 bit: active-low start request.
REQ-008 SHALL have ports zero, carry and sign, inputs, 1 bit each: registered ALU status flags.
REQ-009 SHALL have port microaddress, output, 8 bits: registered address driven to the control store.
REQ-010 SHALL have port enable_op, output, 1 bit: combinational; high while bop=1111.
REQ-011 SHALL have port stack_err, output, 1 bit: registered, sticky.
REQ-012 SHALL have port stack_depth, output, 3 bits: registered occupancy of the return stack (0..4).

Function
REQ-013 Control store SHALL be treated as combinational: the microword for microaddress is valid in the same cycle, and next microaddress SHALL be registered one edge later.
REQ-014 Each edge SHALL compute the next microaddress from bop:
 - 0000, 0110, 1011, 1100, 1101: no load.
 - 0001: load if zero=1.
 - 0010: load if zero=0.
 - 0011: load if carry=1.
 - 0101: load if carry=0.
 - 0100: load if go_bar=1.
 - 0111: load if sign=1.
 - 1010: load if sign=0.
 - 1110: always load.
 - 1000: call.
 - 1001: return.
 - 1111: dispatch.
REQ-015 A load SHALL set microaddress to micro_ad.
REQ-016 No load SHALL give microaddress+1 when count=1, or hold microaddress when count=0.
REQ-017 Increment SHALL wrap from 8'hFF to 8'h00.
REQ-018 Dispatch SHALL set microaddress to {opcode, micro_ad[3:0]}, ignoring micro_ad[7:4].
REQ-019 Call SHALL push microaddress+1 (wrapped) onto a 4-entry LIFO and load micro_ad.
REQ-020 Return SHALL pop the top entry into microaddress.
REQ-021 Call with stack_depth=4 SHALL still branch to micro_ad, SHALL NOT push or alter entries, and SHALL set stack_err.
REQ-022 Return with stack_depth=0 SHALL set microaddress to 8'h00 and SHALL set stack_err.
REQ-023 stack_err SHALL clear only on reset.
REQ-024 stack_depth SHALL change by at most 1 per cycle.
REQ-025 Flag and go_bar inputs SHALL be sampled at the same edge that updates microaddress, with no internal synchronisation.

Reset
REQ-026 reset_n low SHALL asynchronously force microaddress=8'h00, stack_depth=0 and stack_err=0, and SHALL empty the stack.
REQ-027 Reset asserted mid-call or mid-return SHALL discard the in-flight operation.
REQ-028 The first rising edge after reset_n deasserts SHALL evaluate the microword at 8'h00.
REQ-029 Stack entry contents SHALL need no reset, but SHALL never be observable when stack_depth=0.

Structure
REQ-030 A shared package SHALL hold:
 - the BOP encoding constants;
 - RESET_ADDR = 8'h00;
 - STACK_DEPTH = 4;
 - the microword field bit positions: MICRO_AD [7:0], COUNT [8], BOP [12:9].
REQ-031 The return stack SHALL be a separate sub-module, micro_stack, with push, pop, data in, data out, depth and full/empty outputs.
REQ-032 The next-address multiplexer and condition decode SHALL remain in micro_sequencer.

Verification
REQ-033 Reset and idle loop: sequence 00 (bop 1110, micro_ad 0C) -> 0C (bop 0110, count 1) -> 0D (bop 0100, micro_ad 0D) SHALL give microaddress 00, 0C, 0D, then hold at 0D while go_bar=1, then 0E on the first edge with go_bar=0.
REQ-034 Dispatch: at 0E with bop=1111, micro_ad=F1, opcode=4'h3, enable_op SHALL be 1 and the next microaddress SHALL be 8'h31; with opcode=4'hF it SHALL be 8'hF1.
REQ-035 Call/return: at 8'h20, call to 8'h80 SHALL give microaddress 80 and stack_depth 1; a later return SHALL give 8'h21 and stack_depth 0.
REQ-036 Stack overflow and underflow:
 - five nested calls SHALL leave stack_depth=4, with stack_err rising on the fifth call while it still branches;
 - four returns SHALL unwind in LIFO order;
 - a fifth return SHALL go to 8'h00 with stack_err=1.
REQ-037 Hold and wrap: no-load with count=0 at 8'h55 SHALL hold 8'h55 for N cycles; no-load with count=1 at 8'hFF SHALL give 8'h00.
REQ-038 Reset during call: reset_n pulsed low mid-cycle while bop=1000 SHALL immediately give microaddress=8'h00 and stack_depth=0.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: branch-op encodings,
// reset address, return-stack size and microword field positions.
package micro_sequencer_pkg;

  typedef enum logic [3:0] {
    BOP_NEXT      = 4'b0000,
    BOP_JZ        = 4'b0001,
    BOP_JNZ       = 4'b0010,
    BOP_JC        = 4'b0011,
    BOP_JGO       = 4'b0100,
    BOP_JNC       = 4'b0101,
    BOP_NEXT_6    = 4'b0110,
    BOP_JS        = 4'b0111,
    BOP_CALL      = 4'b1000,
    BOP_RET       = 4'b1001,
    BOP_JNS       = 4'b1010,
    BOP_NEXT_B    = 4'b1011,
    BOP_NEXT_C    = 4'b1100,
    BOP_NEXT_D    = 4'b1101,
    BOP_JMP       = 4'b1110,
    BOP_DISPATCH  = 4'b1111
  } bop_e;

  localparam logic [7:0]  RESET_ADDR  = 8'h00;
  localparam int unsigned STACK_DEPTH = 4;

  localparam int unsigned MICRO_AD_LSB = 0;
  localparam int unsigned MICRO_AD_MSB = 7;
  localparam int unsigned COUNT_BIT    = 8;
  localparam int unsigned BOP_LSB      = 9;
  localparam int unsigned BOP_MSB      = 12;

endpackage

// File: rtl/micro_stack.sv
// Four-entry return-address LIFO; entries are unreset storage, masked while empty.
module micro_stack
  import micro_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] depth,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [STACK_DEPTH];
  logic [2:0] depth_q;
  logic [2:0] top_idx;

  assign full    = (depth_q == 3'(STACK_DEPTH));
  assign empty   = (depth_q == 3'd0);
  assign depth   = depth_q;
  assign top_idx = depth_q - 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + 3'd1;
    end else if (pop && !empty) begin
      depth_q <= depth_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[depth_q[1:0]] <= data_in;
    end
  end

  assign data_out = empty ? '0 : mem[top_idx[1:0]];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: condition decode and next-address selection feeding
// a registered control-store address, with a return stack for call/return.
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] micro_ad,
  input  logic       count,
  input  logic [3:0] bop,
  input  logic [3:0] opcode,
  input  logic       go_bar,
  input  logic       zero,
  input  logic       carry,
  input  logic       sign,
  output logic [7:0] microaddress,
  output logic       enable_op,
  output logic       stack_err,
  output logic [2:0] stack_depth
);

  logic [7:0] next_addr;
  logic [7:0] incr_addr;
  logic [7:0] stack_top;
  logic       push;
  logic       pop;
  logic       err_set;
  logic       stack_full;
  logic       stack_empty;

  assign incr_addr = microaddress + 8'd1;
  assign enable_op = (bop == BOP_DISPATCH);

  always_comb begin
    next_addr = count ? incr_addr : microaddress;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (bop)
      BOP_JZ:       if (zero)    next_addr = micro_ad;
      BOP_JNZ:      if (!zero)   next_addr = micro_ad;
      BOP_JC:       if (carry)   next_addr = micro_ad;
      BOP_JNC:      if (!carry)  next_addr = micro_ad;
      BOP_JGO:      if (go_bar)  next_addr = micro_ad;
      BOP_JS:       if (sign)    next_addr = micro_ad;
      BOP_JNS:      if (!sign)   next_addr = micro_ad;
      BOP_JMP:      next_addr = micro_ad;
      BOP_DISPATCH: next_addr = {opcode, micro_ad[3:0]};
      BOP_CALL: begin
        // Overflowing call still branches; the stack is left untouched.
        next_addr = micro_ad;
        push      = !stack_full;
        err_set   = stack_full;
      end
      BOP_RET: begin
        next_addr = stack_empty ? RESET_ADDR : stack_top;
        pop       = !stack_empty;
        err_set   = stack_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      microaddress <= RESET_ADDR;
      stack_err    <= 1'b0;
    end else begin
      microaddress <= next_addr;
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  micro_stack u_stack (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .data_in  (incr_addr),
    .data_out (stack_top),
    .depth    (stack_depth),
    .full     (stack_full),
    .empty    (stack_empty)
  );

endmodule
